// File: rtl/usb_tx_encoder.sv
// usb_tx_encoder: USB full-speed transmit serializer with SYNC, bit stuffing, NRZI and EOP
module usb_tx_encoder #(
  parameter int CLKS_PER_BIT = 8,
  parameter logic [7:0] SYNC_BYTE = 8'h80
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err,
  output logic       d_plus,
  output logic       d_minus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP_SE0, EOP_J} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n, ones, ones_n;
  logic [7:0] sh, sh_n, hold_data, hold_data_n;
  logic cur_last, cur_last_n, hold_last, hold_last_n, hold_full, hold_full_n, aborted, aborted_n;
  logic dp_n, dm_n, busy_n, done_n, err_n, ready_n, emit, eb;
  logic acc, wrap, step;
  assign acc = tx_valid && tx_ready;
  assign wrap = cnt == CW'(CLKS_PER_BIT - 1);
  assign step = wrap && (state == DATA || (state == SYNC && idx == 3'd0));
  always_comb begin
    state_n = state;
    idx_n = idx;
    ones_n = ones;
    sh_n = sh;
    cur_last_n = cur_last;
    hold_data_n = hold_data;
    hold_last_n = hold_last;
    hold_full_n = hold_full;
    aborted_n = aborted;
    dp_n = d_plus;
    dm_n = d_minus;
    busy_n = busy;
    done_n = 1'b0;
    err_n = 1'b0;
    emit = 1'b0;
    eb = 1'b0;
    if (acc) begin
      hold_data_n = tx_data;
      hold_last_n = tx_last;
      hold_full_n = 1'b1;
    end
    if (state == IDLE && (acc || hold_full)) begin
      state_n = SYNC;
      busy_n = 1'b1;
      idx_n = 3'd1;
      cur_last_n = 1'b0;
      aborted_n = 1'b0;
      emit = 1'b1;
      eb = SYNC_BYTE[0];
    end
    if (state == SYNC && wrap && idx != 3'd0) begin
      emit = 1'b1;
      eb = SYNC_BYTE[idx];
      idx_n = idx + 3'd1;
    end
    if (step) begin
      if (ones == 3'd6) begin
        emit = 1'b1;
        eb = 1'b0;
      end else if (idx != 3'd0) begin
        emit = 1'b1;
        eb = sh[0];
        sh_n = sh >> 1;
        idx_n = idx + 3'd1;
      end else if (cur_last || !hold_full) begin
        state_n = EOP_SE0;
        dp_n = 1'b0;
        dm_n = 1'b0;
        err_n = !cur_last;
        aborted_n = !cur_last;
      end else begin
        state_n = DATA;
        emit = 1'b1;
        eb = hold_data[0];
        sh_n = hold_data >> 1;
        cur_last_n = hold_last;
        hold_full_n = 1'b0;
        idx_n = 3'd1;
      end
    end
    if (state == EOP_SE0 && wrap) begin
      idx_n = idx == 3'd1 ? 3'd0 : 3'd1;
      state_n = idx == 3'd1 ? EOP_J : EOP_SE0;
      dp_n = idx == 3'd1;
    end
    if (state == EOP_J) begin
      done_n = cnt == CW'(CLKS_PER_BIT - 2) && !aborted;
      if (wrap) begin
        state_n = IDLE;
        busy_n = 1'b0;
        ones_n = 3'd0;
      end
    end
    if (emit) begin
      dp_n = eb ? d_plus : !d_plus;
      dm_n = !dp_n;
      ones_n = eb ? ones + 3'd1 : 3'd0;
    end
    cnt_n = (state == IDLE || wrap) ? '0 : cnt + CW'(1);
    ready_n = !hold_full_n && state_n != EOP_SE0 && state_n != EOP_J;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= 3'd0;
      ones <= 3'd0;
      sh <= 8'd0;
      cur_last <= 1'b0;
      hold_data <= 8'd0;
      hold_last <= 1'b0;
      hold_full <= 1'b0;
      aborted <= 1'b0;
      d_plus <= 1'b1;
      d_minus <= 1'b0;
      busy <= 1'b0;
      tx_done <= 1'b0;
      tx_err <= 1'b0;
      tx_ready <= 1'b1;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      ones <= ones_n;
      sh <= sh_n;
      cur_last <= cur_last_n;
      hold_data <= hold_data_n;
      hold_last <= hold_last_n;
      hold_full <= hold_full_n;
      aborted <= aborted_n;
      d_plus <= dp_n;
      d_minus <= dm_n;
      busy <= busy_n;
      tx_done <= done_n;
      tx_err <= err_n;
      tx_ready <= ready_n;
    end
  end
endmodule

// File: tb/tb_usb_tx_encoder.sv
// tb_usb_tx_encoder: scoreboard bench for the USB transmit encoder line sequences and handshakes
module tb_usb_tx_encoder;
  localparam int CPB = 8;
  typedef struct {int nbits; bit done; bit err;} pkt_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] tx_data = 8'd0;
  logic tx_valid = 1'b0;
  logic tx_last = 1'b0;
  logic tx_ready, busy, tx_done, tx_err, d_plus, d_minus;
  logic [1:0] line_q[$];
  pkt_t pkt_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit skip = 1'b0;
  bit in_pkt = 1'b0;
  bit pkt_skip = 1'b0;
  int k, bitn, ndone, nerr, done_at, err_at;
  usb_tx_encoder #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'h80)) dut (
    .clk(clk),
    .rst(rst),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_last(tx_last),
    .tx_ready(tx_ready),
    .busy(busy),
    .tx_done(tx_done),
    .tx_err(tx_err),
    .d_plus(d_plus),
    .d_minus(d_minus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic expect_pkt(input string s, input bit done, input bit err);
    byte c;
    for (int i = 0; i < s.len(); i++) begin
      c = s.getc(i);
      line_q.push_back(c == "K" ? 2'b01 : c == "J" ? 2'b10 : 2'b00);
    end
    pkt_q.push_back('{s.len(), done, err});
  endtask
  task automatic send(input logic [7:0] d, input logic l, output int acc);
    int t;
    tx_data = d;
    tx_last = l;
    tx_valid = 1'b1;
    t = 0;
    while (!tx_ready && t < 4000) begin
      @(negedge clk);
      t++;
    end
    chk("accept", tx_ready, 1'b1);
    @(posedge clk);
    acc = cyc;
    @(negedge clk);
  endtask
  task automatic wait_idle();
    int t;
    t = 0;
    while ((busy || pkt_q.size() != 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (busy || pkt_q.size() != 0) begin
      errors++;
      $display("FAIL wait_idle: busy=%0b pending=%0d after %0d cycles, expected idle", busy, pkt_q.size(), t);
    end
    repeat (2) @(negedge clk);
  endtask
  task automatic end_pkt();
    pkt_t p;
    if (pkt_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL pkt: got packet of %0d cycles, expected none", k);
      return;
    end
    p = pkt_q.pop_front();
    chk("pkt_len", k, p.nbits * CPB);
    chk("done_count", ndone, p.done);
    chk("err_count", nerr, p.err);
    if (p.done) chk("done_at", done_at, p.nbits * CPB - 1);
    if (p.err) chk("err_at", err_at, (p.nbits - 3) * CPB);
    chk("idle_line", {d_plus, d_minus}, 2'b10);
  endtask
  always @(negedge clk) begin
    if (rst) in_pkt = 1'b0;
    else if (in_pkt && !busy) begin
      in_pkt = 1'b0;
      if (!pkt_skip) end_pkt();
    end else if (busy) begin
      if (!in_pkt) begin
        in_pkt = 1'b1;
        pkt_skip = skip;
        k = 0;
        bitn = 0;
        ndone = 0;
        nerr = 0;
        done_at = -1;
        err_at = -1;
      end
      if (!pkt_skip && k % CPB == CPB / 2) begin
        if (line_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL line bit %0d: got extra bit period %0b%0b, expected none", bitn, d_plus, d_minus);
        end else chk($sformatf("line bit %0d", bitn), {d_plus, d_minus}, line_q.pop_front());
        bitn++;
      end
      if (tx_done) begin
        ndone++;
        done_at = k;
      end
      if (tx_err) begin
        nerr++;
        err_at = k;
      end
      k++;
    end
  end
  initial begin
    int a1, a2;
    repeat (3) @(negedge clk);
    chk("rst d_plus", d_plus, 1'b1);
    chk("rst d_minus", d_minus, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst tx_ready", tx_ready, 1'b1);
    chk("rst tx_done", tx_done, 1'b0);
    chk("rst tx_err", tx_err, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    expect_pkt("KJKJKJKKJKJKJKJK00J", 1'b1, 1'b0);
    send(8'h00, 1'b1, a1);
    tx_valid = 1'b0;
    wait_idle();
    expect_pkt("KJKJKJKKKKKKKJJJJ00J", 1'b1, 1'b0);
    send(8'hFF, 1'b1, a1);
    tx_valid = 1'b0;
    wait_idle();
    expect_pkt("KJKJKJKKJKKKKKKKJ00J", 1'b1, 1'b0);
    send(8'hFC, 1'b1, a1);
    tx_valid = 1'b0;
    wait_idle();
    expect_pkt("KJKJKJKKKJJKJJKKJKKKKKJK00J", 1'b1, 1'b0);
    send(8'hA5, 1'b0, a1);
    send(8'h3C, 1'b1, a2);
    tx_valid = 1'b0;
    chk("second_accept_gap", a2 - a1, 65);
    wait_idle();
    expect_pkt("KJKJKJKKJKJKKKKKKKJKJKJKJ00J", 1'b1, 1'b0);
    send(8'hF0, 1'b0, a1);
    send(8'h03, 1'b1, a2);
    tx_valid = 1'b0;
    wait_idle();
    expect_pkt("KJKJKJKKJJKJJKJK00J", 1'b0, 1'b1);
    send(8'h12, 1'b0, a1);
    tx_valid = 1'b0;
    wait_idle();
    skip = 1'b1;
    send(8'h00, 1'b1, a1);
    tx_valid = 1'b0;
    repeat (90) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst d_plus", d_plus, 1'b1);
    chk("midrst d_minus", d_minus, 1'b0);
    chk("midrst busy", busy, 1'b0);
    chk("midrst tx_ready", tx_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    skip = 1'b0;
    expect_pkt("KJKJKJKKJKJKJKJK00J", 1'b1, 1'b0);
    send(8'h00, 1'b1, a1);
    tx_valid = 1'b0;
    wait_idle();
    chk("line_q_empty", line_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
